// File: rtl/sips4_input_conditioner.sv
// SIPS4 switch/button front end: 2-flop sync, per-bit debounce, sticky press flags.
// Optional press flags are built only when SIPS4_BTN_LATCH_EN is defined.
module sips4_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] slide_raw,
    input  logic [1:0] button_raw,
    input  logic       rd_strobe,
    input  logic       rd_port,
    output logic [3:0] slide_q,
    output logic [1:0] btn_q,
    output logic [1:0] btn_press,
    output logic [3:0] in_data0,
    output logic [3:0] in_data1,
    output logic       changed
);

    localparam int unsigned NB = 6;
    localparam logic [NB-1:0] SYNC_RST = 6'b110000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic {
        IDLE,
        PEND
    } db_state_e;

    logic [NB-1:0]    sync1_q, sync1_d;
    logic [NB-1:0]    sync2_q, sync2_d;
    logic [NB-1:0]    synced;
    logic [NB-1:0]    stable_q, stable_d;
    logic             changed_q, changed_d;
    db_state_e        state_q [NB];
    db_state_e        state_d [NB];
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];

    always_comb begin
        sync1_d = {button_raw, slide_raw};
        sync2_d = sync1_q;
    end

    // Buttons are active-low at the pin; flip once here so everything after is active-high.
    assign synced = {~sync2_q[5:4], sync2_q[3:0]};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                IDLE: begin
                    cnt_d[i] = CNT_ZERO;
                    if (synced[i] != stable_q[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            stable_d[i] = synced[i];
                        end else begin
                            // The first mismatching edge counts toward the interval.
                            state_d[i] = PEND;
                            cnt_d[i]   = CNT_ONE;
                        end
                    end
                end
                PEND: begin
                    if (synced[i] == stable_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        stable_d[i] = synced[i];
                        state_d[i]  = IDLE;
                        cnt_d[i]    = CNT_ZERO;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = CNT_ZERO;
                end
            endcase
        end
        changed_d = |(stable_d ^ stable_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= SYNC_RST;
            sync2_q   <= SYNC_RST;
            stable_q  <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= CNT_ZERO;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

`ifdef SIPS4_BTN_LATCH_EN
    logic [1:0] press_q, press_d;
    logic [1:0] btn_rise;
    logic       rd_clr;

    assign btn_rise = stable_d[5:4] & ~stable_q[5:4];
    assign rd_clr   = rd_strobe & rd_port;

    // A rise in the same cycle as a clearing read must survive.
    always_comb begin
        press_d = (rd_clr ? 2'b00 : press_q) | btn_rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_q <= 2'b00;
        end else begin
            press_q <= press_d;
        end
    end

    assign btn_press = press_q;
`else
    logic unused_rd;
    assign unused_rd = rd_strobe ^ rd_port;
    assign btn_press = 2'b00;
`endif

    assign slide_q  = stable_q[3:0];
    assign btn_q    = stable_q[5:4];
    assign in_data0 = stable_q[3:0];
    assign in_data1 = {btn_press, stable_q[5:4]};
    assign changed  = changed_q;

endmodule

// File: tb/tb_sips4_input_conditioner.sv
// Directed bench for sips4_input_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3.
// Expectations follow SIPS4_BTN_LATCH_EN when it is defined for the build.
module tb_sips4_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] slide_raw;
    logic [1:0] button_raw;
    logic       rd_strobe;
    logic       rd_port;
    logic [3:0] slide_q;
    logic [1:0] btn_q;
    logic [1:0] btn_press;
    logic [3:0] in_data0;
    logic [3:0] in_data1;
    logic       changed;

    int checks = 0;
    int errors = 0;

`ifdef SIPS4_BTN_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    sips4_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .slide_raw(slide_raw),
        .button_raw(button_raw),
        .rd_strobe(rd_strobe),
        .rd_port(rd_port),
        .slide_q(slide_q),
        .btn_q(btn_q),
        .btn_press(btn_press),
        .in_data0(in_data0),
        .in_data1(in_data1),
        .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        slide_raw  = 4'b0000;
        button_raw = 2'b11;
        rd_strobe  = 1'b0;
        rd_port    = 1'b0;

        tick();
        chk("rst_slide_q", 8'(slide_q), 8'h0);
        chk("rst_btn_q", 8'(btn_q), 8'h0);
        chk("rst_btn_press", 8'(btn_press), 8'h0);
        chk("rst_in_data0", 8'(in_data0), 8'h0);
        chk("rst_in_data1", 8'(in_data1), 8'h0);
        chk("rst_changed", 8'(changed), 8'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle_changed", 8'(changed), 8'h0);
            chk("idle_in_data1", 8'(in_data1), 8'h0);
        end

        // Slide 0 -> 1010, visible only after E0+5
        slide_raw = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("slide_early", 8'(slide_q), 8'h0);
            chk("slide_early_chg", 8'(changed), 8'h0);
        end
        tick();
        chk("slide_q", 8'(slide_q), 8'hA);
        chk("slide_changed", 8'(changed), 8'h1);
        chk("slide_in_data0", 8'(in_data0), 8'hA);
        tick();
        chk("slide_hold", 8'(slide_q), 8'hA);
        chk("slide_chg_once", 8'(changed), 8'h0);

        // 3-cycle glitch on button 0
        button_raw = 2'b10;
        tick();
        tick();
        tick();
        button_raw = 2'b11;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("glitch_btn_q", 8'(btn_q), 8'h0);
            chk("glitch_press", 8'(btn_press), 8'h0);
            chk("glitch_changed", 8'(changed), 8'h0);
        end

        // Press button 0 for 10 cycles
        button_raw = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("press_early", 8'(btn_q), 8'h0);
        end
        tick();
        chk("press_btn_q", 8'(btn_q), 8'h1);
        chk("press_flag", 8'(btn_press), LATCH ? 8'h1 : 8'h0);
        chk("press_changed", 8'(changed), 8'h1);
        chk("press_in_data1", 8'(in_data1), LATCH ? 8'h5 : 8'h1);
        for (int k = 0; k < 4; k++) tick();
        chk("press_held", 8'(in_data1), LATCH ? 8'h5 : 8'h1);
        button_raw = 2'b11;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("release_early", 8'(btn_q), 8'h1);
        end
        tick();
        chk("release_btn_q", 8'(btn_q), 8'h0);
        chk("release_in_data1", 8'(in_data1), LATCH ? 8'h4 : 8'h0);

        // Port-0 read leaves the flag alone
        rd_strobe = 1'b1;
        rd_port   = 1'b0;
        tick();
        rd_strobe = 1'b0;
        chk("rd0_keep", 8'(in_data1), LATCH ? 8'h4 : 8'h0);
        tick();
        chk("rd0_keep2", 8'(in_data1), LATCH ? 8'h4 : 8'h0);

        // Port-1 read clears; pre-clear value seen in the strobe cycle
        rd_strobe = 1'b1;
        rd_port   = 1'b1;
        chk("rd1_preclear", 8'(in_data1), LATCH ? 8'h4 : 8'h0);
        tick();
        rd_strobe = 1'b0;
        rd_port   = 1'b0;
        chk("rd1_clear", 8'(in_data1), 8'h0);

        // Clearing read on the same edge button 1 rises
        button_raw = 2'b01;
        for (int k = 0; k < 5; k++) tick();
        chk("coll_pre", 8'(btn_q), 8'h0);
        rd_strobe = 1'b1;
        rd_port   = 1'b1;
        tick();
        rd_strobe = 1'b0;
        rd_port   = 1'b0;
        chk("coll_btn_q", 8'(btn_q), 8'h2);
        chk("coll_press", 8'(btn_press), LATCH ? 8'h2 : 8'h0);
        chk("coll_in_data1", 8'(in_data1), LATCH ? 8'hA : 8'h2);
        button_raw = 2'b11;
        for (int k = 0; k < 6; k++) tick();
        chk("coll_release", 8'(in_data1), LATCH ? 8'h8 : 8'h0);
        rd_strobe = 1'b1;
        rd_port   = 1'b1;
        tick();
        rd_strobe = 1'b0;
        rd_port   = 1'b0;
        chk("coll_clear", 8'(in_data1), 8'h0);

        // Reset 3 cycles into a slide[2] change
        slide_raw = 4'b1110;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_slide", 8'(slide_q), 8'h0);
        chk("midrst_changed", 8'(changed), 8'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("midrst_early", 8'(slide_q), 8'h0);
        end
        tick();
        chk("midrst_slide_q", 8'(slide_q), 8'hE);
        chk("midrst_changed1", 8'(changed), 8'h1);
        tick();
        chk("midrst_changed0", 8'(changed), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
